// File: rtl/cmul_sequencer.sv
// Signed complex multiplier sequencer: drives one shared unsigned multiplier through the four
// partial products of (a_re + j*a_im) * (b_re + j*b_im) and accumulates re/im.
module cmul_sequencer #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                 clkin,
    input  logic                 rstn_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a_re,
    input  logic [WIDTH-1:0]     a_im,
    input  logic [WIDTH-1:0]     b_re,
    input  logic [WIDTH-1:0]     b_im,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH:0]     out_re,
    output logic [2*WIDTH:0]     out_im,
    output logic                 err,
    output logic                 mul_start,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    input  logic                 mul_done,
    input  logic [2*WIDTH-1:0]   mul_product
);
    localparam int unsigned AW  = 2 * WIDTH + 1;
    localparam int unsigned WDW = $clog2(TIMEOUT);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUT} state_t;

    state_t           r_state;
    logic [1:0]       r_pass;
    logic [WDW-1:0]   r_wdog;
    logic [WIDTH-1:0] r_ar, r_ai, r_br, r_bi;
    logic [AW-1:0]    r_acc_re, r_acc_im;
    logic [AW-1:0]    r_out_re, r_out_im;
    logic [WIDTH-1:0] r_mul_a, r_mul_b;
    logic             r_mul_start, r_err;

    logic [2*WIDTH-1:0] w_cur, w_nxt;
    logic               w_neg;
    logic [AW-1:0]      w_pos, w_term;

    // Operand pair {x, y} for a pass: 0 ar*br, 1 ai*bi, 2 ar*bi, 3 ai*br.
    function automatic logic [2*WIDTH-1:0] f_pair(input logic [1:0] p,
            input logic [WIDTH-1:0] ar, input logic [WIDTH-1:0] ai,
            input logic [WIDTH-1:0] br, input logic [WIDTH-1:0] bi);
        logic [2*WIDTH-1:0] v;
        unique case (p)
            2'd0:    v = {ar, br};
            2'd1:    v = {ai, bi};
            2'd2:    v = {ar, bi};
            default: v = {ai, br};
        endcase
        return v;
    endfunction

    // Most negative value maps to 2^(WIDTH-1), which still fits unsigned.
    function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? ((~x) + WIDTH'(1)) : x;
    endfunction

    always_comb begin
        w_cur  = f_pair(r_pass, r_ar, r_ai, r_br, r_bi);
        w_nxt  = f_pair(r_pass + 2'd1, r_ar, r_ai, r_br, r_bi);
        // Pass 1 (ai*bi) subtracts from re, so fold that into the term sign.
        w_neg  = w_cur[2*WIDTH-1] ^ w_cur[WIDTH-1] ^ (r_pass == 2'd1);
        w_pos  = {1'b0, mul_product};
        w_term = w_neg ? ((~w_pos) + AW'(1)) : w_pos;
    end

    always_ff @(posedge clkin or negedge rstn_in) begin
        if (!rstn_in) begin
            r_state     <= S_IDLE;
            r_pass      <= '0;
            r_wdog      <= '0;
            r_ar        <= '0;
            r_ai        <= '0;
            r_br        <= '0;
            r_bi        <= '0;
            r_acc_re    <= '0;
            r_acc_im    <= '0;
            r_out_re    <= '0;
            r_out_im    <= '0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_mul_start <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_err <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_ar        <= a_re;
                        r_ai        <= a_im;
                        r_br        <= b_re;
                        r_bi        <= b_im;
                        r_acc_re    <= '0;
                        r_acc_im    <= '0;
                        r_out_re    <= '0;
                        r_out_im    <= '0;
                        r_pass      <= '0;
                        r_mul_a     <= f_mag(a_re);
                        r_mul_b     <= f_mag(b_re);
                        r_mul_start <= 1'b1;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_mul_start <= 1'b0;
                    r_wdog      <= '0;
                    r_state     <= S_WAIT;
                end
                S_WAIT: begin
                    if (mul_done) begin
                        if (!r_pass[1]) r_acc_re <= r_acc_re + w_term;
                        else            r_acc_im <= r_acc_im + w_term;
                        if (r_pass == 2'd3) begin
                            r_out_re <= r_acc_re;
                            r_out_im <= r_acc_im + w_term;
                            r_state  <= S_OUT;
                        end else begin
                            r_pass      <= r_pass + 2'd1;
                            r_mul_a     <= f_mag(w_nxt[2*WIDTH-1:WIDTH]);
                            r_mul_b     <= f_mag(w_nxt[WIDTH-1:0]);
                            r_mul_start <= 1'b1;
                            r_state     <= S_ISSUE;
                        end
                    end else if (r_wdog == WD_LAST) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                S_OUT: begin
                    if (out_ready) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_OUT);
    assign out_re    = r_out_re;
    assign out_im    = r_out_im;
    assign err       = r_err;
    assign mul_start = r_mul_start;
    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;
endmodule

// File: tb/tb_cmul_sequencer.sv
// Self-checking bench for cmul_sequencer with a latency-5 multiplier model that can be stalled.
module tb_cmul_sequencer;
    localparam int L = 5;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid, err, mul_start, mul_done;
    logic [7:0]  a_re = '0, a_im = '0, b_re = '0, b_im = '0;
    logic [7:0]  mul_a, mul_b;
    logic [16:0] out_re, out_im;
    logic [15:0] mul_product, prod_hold;
    logic        stall = 1'b0;
    int          cnt;
    int          n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;

    cmul_sequencer #(.WIDTH(8), .TIMEOUT(64)) dut (
        .clkin(clk), .rstn_in(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
        .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
        .err(err), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_done(mul_done), .mul_product(mul_product)
    );

    // Multiplier model: mul_done is high L cycles after the cycle mul_start was high.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt         <= 0;
            mul_done    <= 1'b0;
            mul_product <= '0;
            prod_hold   <= '0;
        end else begin
            mul_done <= 1'b0;
            if (cnt == 1) begin
                mul_done    <= 1'b1;
                mul_product <= prod_hold;
            end
            if (cnt > 0) cnt <= cnt - 1;
            if (mul_start && !stall) begin
                cnt       <= L - 1;
                prod_hold <= {8'd0, mul_a} * {8'd0, mul_b};
            end
        end
    end

    typedef struct {
        int ar, ai, br, bi;
        int exp_re, exp_im, exp_a0;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " in_ready"},  int'(in_ready), 1);
        check({tag, " out_valid"}, int'(out_valid), 0);
        check({tag, " err"},       int'(err), 0);
        check({tag, " mul_start"}, int'(mul_start), 0);
        check({tag, " mul_a"},     int'(mul_a), 0);
        check({tag, " mul_b"},     int'(mul_b), 0);
        check({tag, " out_re"},    int'(out_re), 0);
        check({tag, " out_im"},    int'(out_im), 0);
    endtask

    // Launch one operand set and return at the first negedge with out_valid (or after 200 cycles).
    task automatic run_txn(input int ar, input int ai, input int br, input int bi, input int hold,
                           output int re, output int im, output int lat, output int starts,
                           output int a0);
        a_re = 8'(ar); a_im = 8'(ai); b_re = 8'(br); b_im = 8'(bi);
        in_valid = 1'b1;
        out_ready = (hold == 0);
        lat = 0; starts = 0; a0 = -1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            if (mul_start) begin
                if (starts == 0) a0 = int'(mul_a);
                starts++;
            end
            @(negedge clk);
            lat++;
        end
        re = int'($signed(out_re));
        im = int'($signed(out_im));
    endtask

    initial begin
        int re, im, lat, starts, a0, n;
        bit seen_valid;

        vecs[0] = '{3, 4, 2, -1, 10, 5, 3};
        vecs[1] = '{-128, -128, -128, 127, 32640, 128, 128};
        vecs[2] = '{0, 0, -5, 7, 0, 0, 0};
        vecs[3] = '{5, -3, -2, 4, 2, 26, 5};
        vecs[4] = '{-7, 2, 3, -6, -9, 48, 7};
        vecs[5] = '{127, -128, 127, -128, -255, -32512, 127};

        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_txn(vecs[i].ar, vecs[i].ai, vecs[i].br, vecs[i].bi, 0, re, im, lat, starts, a0);
            check($sformatf("v%0d out_re", i), re, vecs[i].exp_re);
            check($sformatf("v%0d out_im", i), im, vecs[i].exp_im);
            check($sformatf("v%0d latency", i), lat, 4 * L + 5);
            check($sformatf("v%0d mul_start count", i), starts, 4);
            check($sformatf("v%0d pass0 mul_a", i), a0, vecs[i].exp_a0);
            @(negedge clk);
            check($sformatf("v%0d out_valid drop", i), int'(out_valid), 0);
            check($sformatf("v%0d in_ready back", i), int'(in_ready), 1);
            check($sformatf("v%0d out_re held", i), int'($signed(out_re)), vecs[i].exp_re);
        end

        // Consumer back-pressure: result must stay put with no multiplier activity.
        run_txn(-4, 3, 2, 5, 1, re, im, lat, starts, a0);
        check("hold latency", lat, 4 * L + 5);
        for (int c = 0; c < 10; c++) begin
            check($sformatf("hold%0d out_valid", c), int'(out_valid), 1);
            check($sformatf("hold%0d in_ready", c), int'(in_ready), 0);
            check($sformatf("hold%0d mul_start", c), int'(mul_start), 0);
            check($sformatf("hold%0d out_re", c), int'($signed(out_re)), -23);
            check($sformatf("hold%0d out_im", c), int'($signed(out_im)), -14);
            @(negedge clk);
        end
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("release in_ready", int'(in_ready), 1);
        check("release out_valid", int'(out_valid), 0);
        check("release no accept", int'(mul_start), 0);
        in_valid = 1'b0;
        @(negedge clk);
        check("release idle mul_start", int'(mul_start), 0);

        // Stalled multiplier: watchdog fires after 64 WAIT cycles.
        stall = 1'b1;
        a_re = 8'd1; a_im = 8'd2; b_re = 8'd3; b_im = 8'd4;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        seen_valid = 1'b0;
        while (!err && lat < 200) begin
            if (out_valid) seen_valid = 1'b1;
            @(negedge clk);
            lat++;
        end
        check("timeout err cycle", lat, 66);
        check("timeout in_ready", int'(in_ready), 1);
        check("timeout no out_valid", int'(seen_valid), 0);
        @(negedge clk);
        check("timeout err one-shot", int'(err), 0);
        n = 0;
        for (int c = 0; c < 5; c++) begin
            if (out_valid) n++;
            @(negedge clk);
        end
        check("timeout out_valid stays low", n, 0);
        stall = 1'b0;
        run_txn(5, -3, -2, 4, 0, re, im, lat, starts, a0);
        check("post-timeout out_re", re, 2);
        check("post-timeout out_im", im, 26);
        check("post-timeout latency", lat, 4 * L + 5);
        @(negedge clk);

        // Asynchronous reset during the pass-2 wait.
        a_re = 8'd3; a_im = 8'd4; b_re = 8'd2; b_im = 8'hFF;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        starts = 0;
        n = 0;
        while (starts < 3 && n < 200) begin
            if (mul_start) starts++;
            @(negedge clk);
            n++;
        end
        check("reach pass2", starts, 3);
        @(negedge clk);
        check("pass2 mul_a before reset", int'(mul_a), 3);
        #2 rstn = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        run_txn(1, 1, 1, 1, 0, re, im, lat, starts, a0);
        check("after reset out_re", re, 0);
        check("after reset out_im", im, 2);
        check("after reset starts", starts, 4);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
